// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_pkg
//  Brief    : Shared constants and BCD helpers for the slow-tick BCD display.
//  Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam int DIGITS = 4;
    localparam int BCD_W  = 4;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [DIGITS*BCD_W-1:0] bcd_clamp(input logic [DIGITS*BCD_W-1:0] v);
        logic [DIGITS*BCD_W-1:0] r;
        r = v;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[k*BCD_W +: BCD_W] > 4'd9) r[k*BCD_W +: BCD_W] = 4'd9;
        end
        return r;
    endfunction

    // Ripple carry (up) or borrow (down) through the digits, one count per call.
    function automatic logic [DIGITS*BCD_W-1:0] bcd_step(input logic [DIGITS*BCD_W-1:0] v,
                                                         input logic up);
        logic [DIGITS*BCD_W-1:0] r;
        logic [BCD_W-1:0]        d;
        logic                    c;
        r = v;
        c = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            d = v[k*BCD_W +: BCD_W];
            if (c) begin
                if (up) begin
                    if (d == 4'd9) d = 4'd0;
                    else begin d = d + 4'd1; c = 1'b0; end
                end else begin
                    if (d == 4'd0) d = 4'd9;
                    else begin d = d - 4'd1; c = 1'b0; end
                end
            end
            r[k*BCD_W +: BCD_W] = d;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decoder
//  Brief    : BCD digit + blank request to active-low 7-segment code.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/slow_tick_bcd_display.sv
`default_nettype none
// ============================================================================
//  Module   : slow_tick_bcd_display
//  Brief    : Synchronised clk_div ticks drive a 4-digit BCD up/down counter
//             shown on a multiplexed common-anode 7-segment display.
//  Revision : 1.0 - initial release
// ============================================================================
module slow_tick_bcd_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_div,
    input  logic        en,
    input  logic        up,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        tick,
    output logic [15:0] count_bcd,
    output logic        wrap,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int c_ref_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_ref_w-1:0] c_ref_max = c_ref_w'(REFRESH_DIV - 1);

    logic               r_s1, r_s2, r_s3;
    logic [c_ref_w-1:0] r_refresh;
    logic [1:0]         r_sel;
    logic               w_ref_wrap;
    logic [1:0]         w_sel_next;
    logic [3:0]         w_digit_next;
    logic [3:0]         w_blank_vec;
    logic [6:0]         w_seg_next;
    logic               w_at_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
            tick <= 1'b0;
        end else begin
            r_s1 <= clk_div;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            tick <= r_s2 & ~r_s3;
        end
    end

    assign w_at_limit = up ? (count_bcd == 16'h9999) : (count_bcd == 16'h0000);

    // Load wins over a coincident tick and never reports a wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_bcd <= 16'h0000;
            wrap      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count_bcd <= bcd_clamp(load_val);
            end else if (tick && en) begin
                count_bcd <= bcd_step(count_bcd, up);
                wrap      <= w_at_limit;
            end
        end
    end

    assign w_ref_wrap = (r_refresh == c_ref_max);
    assign w_sel_next = w_ref_wrap ? r_sel + 2'd1 : r_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh <= '0;
            r_sel     <= 2'd0;
        end else begin
            r_refresh <= w_ref_wrap ? '0 : r_refresh + c_ref_w'(1);
            r_sel     <= w_sel_next;
        end
    end

    // Digit k is blanked when it and every higher digit are zero.
    assign w_blank_vec[0] = 1'b0;
    generate
        for (genvar k = 1; k < DIGITS; k++) begin : g_lz
            assign w_blank_vec[k] = (BLANK_LZ != 0) &&
                                    (count_bcd[DIGITS*BCD_W-1 : k*BCD_W] == '0);
        end
    endgenerate

    assign w_digit_next = count_bcd[w_sel_next*BCD_W +: BCD_W];

    seg7_decoder u_dec (
        .i_bcd   (w_digit_next),
        .i_blank (w_blank_vec[w_sel_next]),
        .o_seg   (w_seg_next)
    );

    // Decoding from the next slot index keeps an and seg aligned on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= SEG_0;
        end else begin
            an  <= ~(4'b0001 << w_sel_next);
            seg <= w_seg_next;
        end
    end

    assign dp = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_slow_tick_bcd_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_slow_tick_bcd_display
//  Brief    : Scoreboard bench for slow_tick_bcd_display (REFRESH_DIV = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_slow_tick_bcd_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_div;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;
    logic        tick;
    logic [15:0] count_bcd;
    logic        wrap;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    typedef struct {
        logic [15:0] cnt;
        logic        wr;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    slow_tick_bcd_display #(.REFRESH_DIV(4), .BLANK_LZ(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_div   (clk_div),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_val  (load_val),
        .tick      (tick),
        .count_bcd (count_bcd),
        .wrap      (wrap),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] c, input logic w);
        exp_t e;
        e.cnt = c;
        e.wr  = w;
        q.push_back(e);
    endtask

    task automatic do_load(input logic [15:0] v);
        @(negedge clk);
        load_val = v;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // One clk_div high pulse; optional latency checks and load on the tick cycle.
    task automatic pulse(input bit chk_lat, input bit ld_on_tick, input logic [15:0] ld_v);
        @(negedge clk);
        clk_div = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (chk_lat) check($sformatf("tick_lat_e%0d", i), {15'd0, tick}, {15'd0, (i == 2)});
            if (ld_on_tick && i == 2) begin
                load_val = ld_v;
                load     = 1'b1;
            end
            if (ld_on_tick && i == 3) load = 1'b0;
        end
        repeat (2) @(negedge clk);
        clk_div = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Monitor: each observed tick pops one expected post-step state.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tick === 1'b1) begin
                @(negedge clk);
                if (q.size() == 0) begin
                    check("unexpected_tick", 16'd1, 16'd0);
                end else begin
                    e = q.pop_front();
                    check("count_after_tick", count_bcd, e.cnt);
                    check("wrap_after_tick", {15'd0, wrap}, {15'd0, e.wr});
                    @(negedge clk);
                    check("wrap_one_cycle", {15'd0, wrap}, 16'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  exp_an  [4];
        logic [6:0]  exp_seg [4];
        int          k;
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{7'b0100100, 7'b0011001, 7'b1111111, 7'b1111111};

        rst = 1'b1; clk_div = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_count", count_bcd, 16'h0000);
        check("rst_an", {12'd0, an}, 16'h000e);
        check("rst_seg", {9'd0, seg}, 16'h0040);
        check("rst_tick", {15'd0, tick}, 16'd0);
        check("rst_dp", {15'd0, dp}, 16'd1);

        do_load(16'h0009); push(16'h0010, 1'b0); pulse(1'b1, 1'b0, 16'h0);
        do_load(16'h9999); push(16'h0000, 1'b1); pulse(1'b0, 1'b0, 16'h0);
        up = 1'b0;         push(16'h9999, 1'b1); pulse(1'b0, 1'b0, 16'h0);
        en = 1'b0;         push(16'h9999, 1'b0); pulse(1'b0, 1'b0, 16'h0);
                           push(16'h9999, 1'b0); pulse(1'b0, 1'b0, 16'h0);
        en = 1'b1;
        do_load(16'h1000); push(16'h0999, 1'b0); pulse(1'b0, 1'b0, 16'h0);
        up = 1'b1;
        do_load(16'h0199); push(16'h0200, 1'b0); pulse(1'b0, 1'b0, 16'h0);
        push(16'h3959, 1'b0); pulse(1'b1, 1'b1, 16'h3A5F);

        do_load(16'h0042);
        k = 0;
        while (an !== 4'b0111 && k < 40) begin @(negedge clk); k++; end
        while (an !== 4'b1110 && k < 40) begin @(negedge clk); k++; end
        check("scan_align", {15'd0, (k < 40)}, 16'd1);
        for (int s = 0; s < 4; s++) begin
            if (s > 0) repeat (4) @(posedge clk);
            @(negedge clk);
            if (s == 0) begin end
            check($sformatf("scan_an_%0d", s), {12'd0, an}, {12'd0, exp_an[s]});
            check($sformatf("scan_seg_%0d", s), {9'd0, seg}, {9'd0, exp_seg[s]});
            repeat (0) @(posedge clk);
        end

        do_load(16'h0427);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_count", count_bcd, 16'h0000);
        check("arst_an", {12'd0, an}, 16'h000e);
        check("arst_seg", {9'd0, seg}, 16'h0040);
        check("arst_tick", {15'd0, tick}, 16'd0);

        clk_div = 1'b1;
        en = 1'b1; up = 1'b1;
        push(16'h0001, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        clk_div = 1'b0;
        repeat (8) @(negedge clk);

        check("queue_empty", 16'(q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
